// File: rtl/fpga_rst_strap_sequencer_pkg.sv
// Shared types and width helpers for the board reset / strap sequencer.
package fpga_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_e;

    // Width of a counter that must reach n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpga_rst_strap_sequencer_if.sv
// SoC-side bundle: released reset, frozen straps and the exit report.
interface fpga_rst_strap_sequencer_if;
    logic        soc_rst_no;
    logic        boot_select_o;
    logic        execute_from_flash_o;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;

    modport master (
        output soc_rst_no,
        output boot_select_o,
        output execute_from_flash_o,
        input  exit_valid_i,
        input  exit_value_i
    );

    modport slave (
        input  soc_rst_no,
        input  boot_select_o,
        input  execute_from_flash_o,
        output exit_valid_i,
        output exit_value_i
    );
endinterface

// File: rtl/fpga_rst_strap_sequencer_debounce.sv
// Pushbutton synchroniser and debouncer; press_o pulses on an accepted 0->1 change.
module fpga_debounce
    import fpga_rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          btn_s;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (btn_s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Pulse in the cycle the rising toggle is decided, so the FSM acts on the same edge.
    assign press_o = (btn_s != level_q) && (cnt_q == CNT_LAST) && !level_q;
    assign level_o = level_q;

endmodule

// File: rtl/fpga_rst_strap_sequencer.sv
// Board reset / boot-strap sequencer: lock wait, timed SoC reset, strap freeze, exit LEDs.
// Optional auto-reboot from DONE is enabled by defining FPGA_RST_SEQ_AUTO_RESTART_EN.
//
// state     | meaning
// WAIT_LOCK | SoC in reset, waiting for clock wizard lock
// HOLD      | SoC in reset, counting HOLD_CYCLES before strap latch and release
// RUN       | SoC released, waiting for the program exit report
// DONE      | exit reported, LEDs latched, SoC still running
module fpga_rst_strap_sequencer
    import fpga_rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int RESTART_CYCLES  = 50000000
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               pll_locked_i,
    input  logic                               btn_rst_i,
    input  logic                               boot_select_i,
    input  logic                               execute_from_flash_i,
    fpga_rst_strap_sequencer_if.master         soc,
    output logic                               exit_ok_o,
    output logic                               exit_fail_o,
    output logic [1:0]                         state_o
);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || RESTART_CYCLES < 2) begin : g_bad_param
        $error("fpga_rst_strap_sequencer: cycle parameters must be >= 2");
    end

    localparam int HCW = cnt_width(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    // Bit order: {lock, boot_select, execute_from_flash}
    logic [2:0] sync1_q, sync2_q;
    logic       lock_s, boot_s, xip_s;
    logic       btn_press;

    seq_state_e     state_q;
    logic [HCW-1:0] hold_cnt_q;
    logic           soc_rst_n_q;
    logic           boot_q, xip_q;
    logic           exit_ok_q, exit_fail_q;

`ifdef FPGA_RST_SEQ_AUTO_RESTART_EN
    localparam int RCW = cnt_width(RESTART_CYCLES);
    localparam logic [RCW-1:0] RESTART_LAST = RCW'(RESTART_CYCLES - 1);
    logic [RCW-1:0] restart_cnt_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {pll_locked_i, boot_select_i, execute_from_flash_i};
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q[2];
    assign boot_s = sync2_q[1];
    assign xip_s  = sync2_q[0];

    fpga_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_rst_i),
        .level_o (),
        .press_o (btn_press)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_WAIT_LOCK;
            hold_cnt_q  <= '0;
            soc_rst_n_q <= 1'b0;
            boot_q      <= 1'b0;
            xip_q       <= 1'b0;
            exit_ok_q   <= 1'b0;
            exit_fail_q <= 1'b0;
`ifdef FPGA_RST_SEQ_AUTO_RESTART_EN
            restart_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_q    <= ST_WAIT_LOCK;
                        hold_cnt_q <= '0;
                    end else if (btn_press) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= ST_RUN;
                        hold_cnt_q  <= '0;
                        boot_q      <= boot_s;
                        xip_q       <= xip_s;
                        soc_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HCW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_q     <= ST_WAIT_LOCK;
                        soc_rst_n_q <= 1'b0;
                        exit_ok_q   <= 1'b0;
                        exit_fail_q <= 1'b0;
                    end else if (btn_press) begin
                        state_q     <= ST_HOLD;
                        hold_cnt_q  <= '0;
                        soc_rst_n_q <= 1'b0;
                        exit_ok_q   <= 1'b0;
                        exit_fail_q <= 1'b0;
                    end else if (soc.exit_valid_i) begin
                        state_q     <= ST_DONE;
                        exit_ok_q   <= (soc.exit_value_i == 32'd0);
                        exit_fail_q <= (soc.exit_value_i != 32'd0);
`ifdef FPGA_RST_SEQ_AUTO_RESTART_EN
                        restart_cnt_q <= '0;
`endif
                    end
                end
                ST_DONE: begin
                    if (!lock_s) begin
                        state_q     <= ST_WAIT_LOCK;
                        soc_rst_n_q <= 1'b0;
                        exit_ok_q   <= 1'b0;
                        exit_fail_q <= 1'b0;
                    end else if (btn_press) begin
                        state_q     <= ST_HOLD;
                        hold_cnt_q  <= '0;
                        soc_rst_n_q <= 1'b0;
                        exit_ok_q   <= 1'b0;
                        exit_fail_q <= 1'b0;
`ifdef FPGA_RST_SEQ_AUTO_RESTART_EN
                    end else if (restart_cnt_q == RESTART_LAST) begin
                        state_q       <= ST_HOLD;
                        hold_cnt_q    <= '0;
                        restart_cnt_q <= '0;
                        soc_rst_n_q   <= 1'b0;
                        exit_ok_q     <= 1'b0;
                        exit_fail_q   <= 1'b0;
                    end else begin
                        restart_cnt_q <= restart_cnt_q + RCW'(1);
`endif
                    end
                end
                default: begin
                    state_q     <= ST_WAIT_LOCK;
                    soc_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign soc.soc_rst_no           = soc_rst_n_q;
    assign soc.boot_select_o        = boot_q;
    assign soc.execute_from_flash_o = xip_q;
    assign exit_ok_o                = exit_ok_q;
    assign exit_fail_o              = exit_fail_q;
    assign state_o                  = state_q;

endmodule

// File: tb/tb_fpga_rst_strap_sequencer.sv
// Scoreboard bench for fpga_rst_strap_sequencer (DEBOUNCE=8, HOLD=16, RESTART=32).
module tb_fpga_rst_strap_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       pll_locked_i;
    logic       btn_rst_i;
    logic       boot_select_i;
    logic       execute_from_flash_i;
    logic       exit_ok_o;
    logic       exit_fail_o;
    logic [1:0] state_o;

    fpga_rst_strap_sequencer_if soc_if();

    fpga_rst_strap_sequencer #(
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (16),
        .RESTART_CYCLES  (32)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .pll_locked_i         (pll_locked_i),
        .btn_rst_i            (btn_rst_i),
        .boot_select_i        (boot_select_i),
        .execute_from_flash_i (execute_from_flash_i),
        .soc                  (soc_if.master),
        .exit_ok_o            (exit_ok_o),
        .exit_fail_o          (exit_fail_o),
        .state_o              (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      tag;
        int         cyc;
        logic [6:0] exp;
    } snap_t;

    typedef struct {
        string tag;
        int    cyc;
        logic  lvl;
    } edge_t;

    snap_t snap_q[$];
    edge_t edge_q[$];
    int    edge_n = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    logic  soc_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // {soc_rst_no, state[1:0], boot_select_o, execute_from_flash_o, exit_ok_o, exit_fail_o}
    function automatic logic [6:0] exp_vec(input bit soc, input logic [1:0] st, input bit b,
                                           input bit x, input bit ok, input bit fl);
        return {soc, st, b, x, ok, fl};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {soc_if.soc_rst_no, state_o, soc_if.boot_select_o,
                soc_if.execute_from_flash_o, exit_ok_o, exit_fail_o};
    endfunction

    task automatic push_snap(input string tag, input int cyc, input logic [6:0] e);
        snap_t s;
        s.tag = tag; s.cyc = cyc; s.exp = e;
        snap_q.push_back(s);
    endtask

    task automatic push_edge(input string tag, input int cyc, input logic lvl);
        edge_t e;
        e.tag = tag; e.cyc = cyc; e.lvl = lvl;
        edge_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    always @(posedge clk_i) edge_n++;

    // Monitor: every soc_rst_no transition must match the next scheduled one.
    always @(negedge clk_i) begin
        if (soc_if.soc_rst_no !== soc_prev) begin
            if (edge_q.size() == 0) begin
                chk("soc_edge_unexpected", edge_n, 32'hFFFF_FFFF);
            end else begin
                edge_t e;
                e = edge_q.pop_front();
                chk(e.tag, edge_n, e.cyc);
                chk({e.tag, "_lvl"}, {31'd0, soc_if.soc_rst_no}, {31'd0, e.lvl});
            end
            soc_prev = soc_if.soc_rst_no;
        end
        for (int i = snap_q.size() - 1; i >= 0; i--) begin
            if (snap_q[i].cyc == edge_n) begin
                chk(snap_q[i].tag, {25'd0, obs_vec()}, {25'd0, snap_q[i].exp});
                snap_q.delete(i);
            end
        end
    end

    initial begin
        int  n;
        int  t0;
        bit  exp_fail_led;
        logic [1:0] st_before_loss;

        rst_ni               = 1'b1;
        pll_locked_i         = 1'b0;
        btn_rst_i            = 1'b0;
        boot_select_i        = 1'b1;
        execute_from_flash_i = 1'b0;
        soc_if.exit_valid_i  = 1'b0;
        soc_if.exit_value_i  = 32'd0;
        #1 rst_ni = 1'b0;
        tick(3);
        chk("reset_vec", {25'd0, obs_vec()}, 32'd0);

        // Lock at edge 5 -> release at edge 23
        rst_ni = 1'b1;
        t0 = edge_n;
        push_snap("post_release", t0 + 1, exp_vec(0, 2'd0, 0, 0, 0, 0));
        tick(4);
        pll_locked_i = 1'b1;
        push_edge("boot_release", t0 + 23, 1'b1);
        push_snap("lock_sync_wait", t0 + 6, exp_vec(0, 2'd0, 0, 0, 0, 0));
        push_snap("hold_entry", t0 + 7, exp_vec(0, 2'd1, 0, 0, 0, 0));
        push_snap("hold_last", t0 + 22, exp_vec(0, 2'd1, 0, 0, 0, 0));
        push_snap("run_entry", t0 + 23, exp_vec(1, 2'd2, 1, 0, 0, 0));
        tick(21);

        // Strap pins change during RUN
        boot_select_i        = 1'b0;
        execute_from_flash_i = 1'b1;
        n = edge_n;
        push_snap("strap_frozen", n + 10, exp_vec(1, 2'd2, 1, 0, 0, 0));
        tick(12);

        // Short bounce is rejected
        btn_rst_i = 1'b1;
        tick(5);
        btn_rst_i = 1'b0;
        n = edge_n;
        push_snap("short_btn", n + 10, exp_vec(1, 2'd2, 1, 0, 0, 0));
        tick(12);

        // Long press: reset at edge 10, release 16 later with resampled straps
        btn_rst_i = 1'b1;
        n = edge_n;
        push_edge("btn_fall", n + 10, 1'b0);
        push_edge("btn_rise", n + 26, 1'b1);
        push_snap("btn_hold", n + 10, exp_vec(0, 2'd1, 1, 0, 0, 0));
        push_snap("btn_resample", n + 26, exp_vec(1, 2'd2, 0, 1, 0, 0));
        push_snap("btn_release_ignored", n + 40, exp_vec(1, 2'd2, 0, 1, 0, 0));
        tick(20);
        btn_rst_i = 1'b0;
        tick(22);

        // Exit with value 0
        soc_if.exit_valid_i = 1'b1;
        soc_if.exit_value_i = 32'd0;
        n = edge_n;
        push_snap("exit_ok", n + 1, exp_vec(1, 2'd3, 0, 1, 1, 0));
        tick(1);
        soc_if.exit_valid_i = 1'b0;
        soc_if.exit_value_i = 32'hDEAD;
        tick(3);

        // Second exit pulse in DONE is ignored
        soc_if.exit_valid_i = 1'b1;
        soc_if.exit_value_i = 32'd5;
        n = edge_n;
        push_snap("done_ignore", n + 2, exp_vec(1, 2'd3, 0, 1, 1, 0));
        tick(1);
        soc_if.exit_valid_i = 1'b0;
        tick(3);

        // Reboot from DONE via button
        btn_rst_i = 1'b1;
        n = edge_n;
        push_edge("reboot_fall", n + 10, 1'b0);
        push_edge("reboot_rise", n + 26, 1'b1);
        push_snap("reboot_clear", n + 10, exp_vec(0, 2'd1, 0, 1, 0, 0));
        tick(12);
        btn_rst_i = 1'b0;
        tick(16);

        // Nonzero exit
        soc_if.exit_valid_i = 1'b1;
        soc_if.exit_value_i = 32'd3;
        n = edge_n;
        push_snap("exit_fail", n + 1, exp_vec(1, 2'd3, 0, 1, 0, 1));
        tick(1);
        soc_if.exit_valid_i = 1'b0;
        soc_if.exit_value_i = 32'd0;
`ifdef FPGA_RST_SEQ_AUTO_RESTART_EN
        push_snap("restart_pre", n + 32, exp_vec(1, 2'd3, 0, 1, 0, 1));
        push_edge("restart_fall", n + 33, 1'b0);
        push_snap("restart_hold", n + 33, exp_vec(0, 2'd1, 0, 1, 0, 0));
        push_edge("restart_rise", n + 49, 1'b1);
        tick(55);
        exp_fail_led   = 1'b0;
        st_before_loss = 2'd2;
`else
        push_snap("done_persist", n + 1000, exp_vec(1, 2'd3, 0, 1, 0, 1));
        tick(1002);
        exp_fail_led   = 1'b1;
        st_before_loss = 2'd3;
`endif

        // Lock loss while running
        pll_locked_i = 1'b0;
        n = edge_n;
        push_snap("lock_loss_pre", n + 2, exp_vec(1, st_before_loss, 0, 1, 0, exp_fail_led));
        push_edge("lock_loss_fall", n + 3, 1'b0);
        push_snap("lock_loss", n + 3, exp_vec(0, 2'd0, 0, 1, 0, 0));
        tick(5);

        // Relock, then drop lock at hold count 7: straps must not latch
        boot_select_i        = 1'b1;
        execute_from_flash_i = 1'b0;
        pll_locked_i         = 1'b1;
        n = edge_n;
        push_snap("hold_cnt7", n + 10, exp_vec(0, 2'd1, 0, 1, 0, 0));
        push_snap("hold_abort_late", n + 12, exp_vec(0, 2'd1, 0, 1, 0, 0));
        push_snap("hold_abort", n + 13, exp_vec(0, 2'd0, 0, 1, 0, 0));
        tick(10);
        pll_locked_i = 1'b0;
        tick(6);

        // Full relock: complete 16-cycle hold
        pll_locked_i = 1'b1;
        n = edge_n;
        push_snap("relock_pre", n + 18, exp_vec(0, 2'd1, 0, 1, 0, 0));
        push_edge("relock_rise", n + 19, 1'b1);
        push_snap("relock_run", n + 19, exp_vec(1, 2'd2, 1, 0, 0, 0));
        tick(22);

        // Asynchronous reset between clock edges
        #2 rst_ni = 1'b0;
        #1 chk("async_reset", {25'd0, obs_vec()}, 32'd0);
        push_edge("async_fall", edge_n + 1, 1'b0);
        tick(3);

        chk("snap_leftover", snap_q.size(), 32'd0);
        chk("edge_leftover", edge_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
